cdb_arbiter: RTL

- Single-port Common Data Bus arbiter sitting between the execute-stage functional units and the CDB consumers (RS, ROB, map table).
- Each cycle it selects at most one FU holding a completed result and returns the per-FU ack that frees that FU.
- It registers the winner's tag/value as the CDB broadcast for the next cycle.
- Grant is round-robin for fairness across ALU, load, store and mult FUs; squash and stall inputs suppress broadcasting.

---
 rtl/cdb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdb_arbiter: round-robin single-port Common Data Bus arbiter.              |
// | Optional perf counters enabled by defining CDB_PERF_CNT_EN.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cdb_arbiter #(
  parameter int NUM_REQ = 7,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  input  logic                      stall,
  input  logic                      squash,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [SRC_W-1:0]          cdb_src
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]               perf_bcast_cnt,
  output logic [31:0]               perf_conflict_cnt
`endif
);

  logic [SRC_W-1:0] r_rr_ptr;
  logic             r_cdb_valid;
  logic             w_found;
  logic             w_grant_en;
  logic [SRC_W-1:0] w_gidx;
  logic [SRC_W:0]   w_sum;
  logic [SRC_W-1:0] w_ptr_next;

  // Rotating priority scan starting at r_rr_ptr; first set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(j);
      if (w_sum >= (SRC_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (SRC_W+1)'(NUM_REQ);
      end
      if (!w_found && req[w_sum[SRC_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_sum[SRC_W-1:0];
      end
    end
  end

  assign w_grant_en = w_found & ~stall & ~squash & ~reset;
  assign ack        = w_grant_en ? (NUM_REQ'(1) << w_gidx) : '0;
  assign w_ptr_next = (w_gidx == SRC_W'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;

  // A squash kills the broadcast already sitting on the bus this cycle.
  assign cdb_valid  = r_cdb_valid & ~squash;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      cdb_tag     <= '0;
      cdb_value   <= '0;
      cdb_src     <= '0;
    end else begin
      r_cdb_valid <= w_grant_en;
      if (w_grant_en) begin
        r_rr_ptr  <= w_ptr_next;
        cdb_tag   <= req_tag[w_gidx*TAG_W +: TAG_W];
        cdb_value <= req_value[w_gidx*DATA_W +: DATA_W];
        cdb_src   <= w_gidx;
      end
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic w_conflict;
  assign w_conflict = (req & (req - NUM_REQ'(1))) != '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_bcast_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (w_grant_en) perf_bcast_cnt <= perf_bcast_cnt + 32'd1;
      if (w_conflict) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule
`default_nettype wire
